pipemem_dcache: RTL and testbench

//  MEM-stage data cache. It sits between the EX/MEM register outputs (malu, mb, mwmem, mm2reg)
//  and the MEM/WB register, and produces mmo and mem_ready for that register.

---
 rtl/pipemem_dcache_if.sv | 14 +
 rtl/pipemem_dcache.sv | 175 +++++++++++++++++
 tb/tb_pipemem_dcache.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipemem_dcache_if.sv
// Word bus between the MEM-stage data cache (master) and external memory (slave).
interface pipemem_dcache_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              ack;

  modport master (output req, we, addr, wdata, input rdata, ack);
  modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/pipemem_dcache.sv
// MEM-stage direct-mapped, write-through, no-write-allocate data cache on a word bus.
// Optional load hit/miss counters are built when DCACHE_STATS_EN is defined.
module pipemem_dcache #(
  parameter int unsigned INDEX_W  = 4,
  parameter int unsigned OFFSET_W = 2,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  mwmem,
  input  logic                  mm2reg,
  input  logic [ADDR_W-1:0]     malu,
  input  logic [31:0]           mb,
  input  logic                  imem_ready,
  output logic [31:0]           mmo,
  output logic                  mem_ready,
  pipemem_dcache_if.master      bus,
  output logic [31:0]           hit_cnt,
  output logic [31:0]           miss_cnt
);
  localparam int unsigned TAG_W = ADDR_W - INDEX_W - OFFSET_W - 2;
  localparam int unsigned LINES = 1 << INDEX_W;
  localparam int unsigned WORDS = 1 << OFFSET_W;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_REFILL = 2'd1;
  localparam logic [1:0] S_WRITE  = 2'd2;
  localparam logic [1:0] S_HELD   = 2'd3;

  logic [1:0]              state, state_nxt;
  logic [OFFSET_W-1:0]     k, k_nxt;
  logic                    req_nxt, we_nxt;
  logic [ADDR_W-1:0]       addr_nxt;
  logic [31:0]             wdata_nxt;

  logic [31:0]             data_mem [LINES*WORDS];
  logic [TAG_W-1:0]        tag_mem  [LINES];
  logic [LINES-1:0]        valid;

  logic [ADDR_W-1:0]       word_addr;
  logic [INDEX_W-1:0]      idx;
  logic [OFFSET_W-1:0]     off;
  logic [TAG_W-1:0]        tag_in;
  logic                    hit, is_load, is_store, ack_c;
  logic                    fill_we, store_we, line_set, line_clr;

  // Address split; byte-offset bits are masked off so bus addresses are word aligned.
  assign word_addr = malu & ~ADDR_W'(3);
  assign off       = word_addr[2 +: OFFSET_W];
  assign idx       = word_addr[OFFSET_W+2 +: INDEX_W];
  assign tag_in    = word_addr[ADDR_W-1 -: TAG_W];
  assign hit       = valid[idx] && (tag_mem[idx] == tag_in);
  assign is_store  = mwmem;
  assign is_load   = mm2reg & ~mwmem;
  assign ack_c     = bus.ack & bus.req;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      k         <= '0;
      bus.req   <= 1'b0;
      bus.we    <= 1'b0;
      bus.addr  <= '0;
      bus.wdata <= '0;
    end else begin
      state     <= state_nxt;
      k         <= k_nxt;
      bus.req   <= req_nxt;
      bus.we    <= we_nxt;
      bus.addr  <= addr_nxt;
      bus.wdata <= wdata_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    req_nxt   = bus.req;
    we_nxt    = bus.we;
    addr_nxt  = bus.addr;
    wdata_nxt = bus.wdata;
    fill_we   = 1'b0;
    store_we  = 1'b0;
    line_set  = 1'b0;
    line_clr  = 1'b0;
    mem_ready = 1'b0;
    mmo       = 32'd0;
    case (state)
      S_IDLE: begin
        mem_ready = !(mwmem || mm2reg) || (is_load && hit);
        if (is_store) begin
          state_nxt = S_WRITE;
          req_nxt   = 1'b1;
          we_nxt    = 1'b1;
          addr_nxt  = word_addr;
          wdata_nxt = mb;
        end else if (is_load) begin
          if (hit) begin
            mmo = data_mem[{idx, off}];
          end else begin
            state_nxt = S_REFILL;
            req_nxt   = 1'b1;
            we_nxt    = 1'b0;
            addr_nxt  = {tag_in, idx, OFFSET_W'(0), 2'b00};
            k_nxt     = '0;
            line_clr  = 1'b1;
          end
        end
      end
      S_REFILL: begin
        if (ack_c) begin
          fill_we = 1'b1;
          if (&k) begin
            line_set  = 1'b1;
            req_nxt   = 1'b0;
            state_nxt = S_IDLE;
          end else begin
            k_nxt    = k + OFFSET_W'(1);
            addr_nxt = {tag_in, idx, k + OFFSET_W'(1), 2'b00};
          end
        end
      end
      S_WRITE: begin
        if (ack_c) begin
          req_nxt   = 1'b0;
          store_we  = hit;
          state_nxt = S_HELD;
        end
      end
      S_HELD: begin
        mem_ready = 1'b1;
        if (imem_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Line invalidated at refill start so an aborted refill never leaves a stale-but-valid line.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)         valid      <= '0;
    else if (line_clr) valid[idx] <= 1'b0;
    else if (line_set) valid[idx] <= 1'b1;
  end

  always_ff @(posedge clock) begin
    if (fill_we)  data_mem[{idx, k}]   <= bus.rdata;
    if (store_we) data_mem[{idx, off}] <= mb;
    if (line_set) tag_mem[idx]         <= tag_in;
  end

`ifdef DCACHE_STATS_EN
  logic refill_done, hit_ev, miss_ev;

  // The hit that completes a refilled load is already counted as a miss.
  assign hit_ev  = (state == S_IDLE) && is_load && hit && imem_ready && !refill_done;
  assign miss_ev = (state == S_IDLE) && is_load && !hit;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      refill_done <= 1'b0;
      hit_cnt     <= 32'd0;
      miss_cnt    <= 32'd0;
    end else begin
      if (line_set)                                        refill_done <= 1'b1;
      else if ((state == S_IDLE) && mem_ready && imem_ready) refill_done <= 1'b0;
      if (hit_ev && (hit_cnt != 32'hFFFF_FFFF))   hit_cnt  <= hit_cnt + 32'd1;
      if (miss_ev && (miss_cnt != 32'hFFFF_FFFF)) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`else
  assign hit_cnt  = 32'd0;
  assign miss_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipemem_dcache.sv
// Directed self-checking bench for pipemem_dcache with a 2-cycle-latency bus responder.
module tb_pipemem_dcache;
`ifdef DCACHE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        mwmem, mm2reg, imem_ready;
  logic [31:0] malu, mb, mmo, hit_cnt, miss_cnt;
  logic        mem_ready;

  pipemem_dcache_if #(.ADDR_W(32)) bus ();

  pipemem_dcache dut (
    .clock(clock), .reset(reset), .mwmem(mwmem), .mm2reg(mm2reg), .malu(malu), .mb(mb),
    .imem_ready(imem_ready), .mmo(mmo), .mem_ready(mem_ready), .bus(bus),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clock = ~clock;

  int          pass_cnt = 0;
  int          chk_cnt  = 0;
  int          n_rd     = 0;
  int          n_wr     = 0;
  int          resp_cnt = 0;
  logic [31:0] rd_log [64];
  logic [31:0] last_waddr, last_wdata;

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    return 32'hC0DE_0000 | a;
  endfunction

  // Bus slave: acks each request on its second cycle, one cycle gap after every ack.
  initial begin
    bus.ack   = 1'b0;
    bus.rdata = 32'd0;
    forever begin
      @(negedge clock);
      if (reset || bus.ack) begin
        bus.ack  = 1'b0;
        resp_cnt = 0;
      end else if (bus.req) begin
        resp_cnt++;
        if (resp_cnt >= 2) begin
          bus.ack  = 1'b1;
          resp_cnt = 0;
          if (bus.we) begin
            n_wr++;
            last_waddr = bus.addr;
            last_wdata = bus.wdata;
          end else begin
            bus.rdata = rd_model(bus.addr);
            if (n_rd < 64) rd_log[n_rd] = bus.addr;
            n_rd++;
          end
        end
      end else begin
        resp_cnt = 0;
      end
    end
  end

  task automatic drive(input logic st, input logic ld, input logic [31:0] a, input logic [31:0] d);
    @(negedge clock);
    mwmem = st; mm2reg = ld; malu = a; mb = d;
    #1;
  endtask

  task automatic wait_ready(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clock);
      #1;
      if (mem_ready) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    mwmem = 0; mm2reg = 0; malu = 0; mb = 0; imem_ready = 1; reset = 1;
    repeat (3) @(negedge clock);
    #1;
    chk_cnt++; if (mem_ready !== 1'b1) $display("FAIL rst_ready got %b want 1", mem_ready); else pass_cnt++;
    chk_cnt++; if (mmo !== 32'd0) $display("FAIL rst_mmo got %h want 0", mmo); else pass_cnt++;
    chk_cnt++; if (bus.req !== 1'b0) $display("FAIL rst_req got %b want 0", bus.req); else pass_cnt++;
    chk_cnt++; if (bus.we !== 1'b0) $display("FAIL rst_we got %b want 0", bus.we); else pass_cnt++;
    chk_cnt++; if (bus.addr !== 32'd0) $display("FAIL rst_addr got %h want 0", bus.addr); else pass_cnt++;
    chk_cnt++; if (bus.wdata !== 32'd0) $display("FAIL rst_wdata got %h want 0", bus.wdata); else pass_cnt++;
    chk_cnt++; if (hit_cnt !== 32'd0) $display("FAIL rst_hit_cnt got %0d want 0", hit_cnt); else pass_cnt++;
    chk_cnt++; if (miss_cnt !== 32'd0) $display("FAIL rst_miss_cnt got %0d want 0", miss_cnt); else pass_cnt++;
    @(negedge clock);
    reset = 0;
  endtask

  task automatic test_refill;
    int base; bit ok;
    base = n_rd;
    drive(0, 1, 32'h100, 0);
    chk_cnt++; if (mem_ready !== 1'b0) $display("FAIL t1_stall got %b want 0", mem_ready); else pass_cnt++;
    wait_ready(80, ok);
    chk_cnt++; if (!ok) $display("FAIL t1_timeout got 0 want 1"); else pass_cnt++;
    chk_cnt++; if ((n_rd - base) !== 4) $display("FAIL t1_nreads got %0d want 4", n_rd - base); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      chk_cnt++;
      if (rd_log[base+i] !== 32'h100 + 32'(4*i))
        $display("FAIL t1_raddr%0d got %h want %h", i, rd_log[base+i], 32'h100 + 32'(4*i));
      else pass_cnt++;
    end
    chk_cnt++; if (mmo !== 32'hC0DE_0100) $display("FAIL t1_mmo got %h want C0DE0100", mmo); else pass_cnt++;
    chk_cnt++; if (miss_cnt !== (STATS ? 32'd1 : 32'd0)) $display("FAIL t1_miss_cnt got %0d want %0d", miss_cnt, STATS ? 1 : 0); else pass_cnt++;
  endtask

  task automatic test_hit;
    drive(0, 1, 32'h104, 0);
    chk_cnt++; if (mem_ready !== 1'b1) $display("FAIL t2_ready got %b want 1", mem_ready); else pass_cnt++;
    chk_cnt++; if (mmo !== 32'hC0DE_0104) $display("FAIL t2_mmo got %h want C0DE0104", mmo); else pass_cnt++;
    chk_cnt++; if (bus.req !== 1'b0) $display("FAIL t2_req got %b want 0", bus.req); else pass_cnt++;
    drive(0, 0, 0, 0);
    chk_cnt++; if (hit_cnt !== (STATS ? 32'd1 : 32'd0)) $display("FAIL t2_hit_cnt got %0d want %0d", hit_cnt, STATS ? 1 : 0); else pass_cnt++;
  endtask

  task automatic test_store_hit;
    int bw; bit ok;
    bw = n_wr;
    drive(1, 0, 32'h108, 32'hDEAD_BEEF);
    chk_cnt++; if (mem_ready !== 1'b0) $display("FAIL t3_stall got %b want 0", mem_ready); else pass_cnt++;
    wait_ready(40, ok);
    chk_cnt++; if (!ok) $display("FAIL t3_timeout got 0 want 1"); else pass_cnt++;
    chk_cnt++; if ((n_wr - bw) !== 1) $display("FAIL t3_nwrites got %0d want 1", n_wr - bw); else pass_cnt++;
    chk_cnt++; if (last_waddr !== 32'h108) $display("FAIL t3_waddr got %h want 108", last_waddr); else pass_cnt++;
    chk_cnt++; if (last_wdata !== 32'hDEAD_BEEF) $display("FAIL t3_wdata got %h want DEADBEEF", last_wdata); else pass_cnt++;
    drive(0, 1, 32'h108, 0);
    chk_cnt++; if (mem_ready !== 1'b1) $display("FAIL t3_ld_ready got %b want 1", mem_ready); else pass_cnt++;
    chk_cnt++; if (mmo !== 32'hDEAD_BEEF) $display("FAIL t3_ld_mmo got %h want DEADBEEF", mmo); else pass_cnt++;
    chk_cnt++; if (bus.req !== 1'b0) $display("FAIL t3_ld_req got %b want 0", bus.req); else pass_cnt++;
    drive(0, 0, 0, 0);
    chk_cnt++; if ((n_wr - bw) !== 1) $display("FAIL t3_nwrites_after got %0d want 1", n_wr - bw); else pass_cnt++;
  endtask

  task automatic test_store_miss_stall;
    int bw, base; bit ok;
    bw = n_wr;
    imem_ready = 0;
    drive(1, 0, 32'h2000, 32'h1234_5678);
    wait_ready(40, ok);
    chk_cnt++; if (!ok) $display("FAIL t4_timeout got 0 want 1"); else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock); #1;
      chk_cnt++; if (mem_ready !== 1'b1) $display("FAIL t4_held_ready%0d got %b want 1", i, mem_ready); else pass_cnt++;
    end
    chk_cnt++; if ((n_wr - bw) !== 1) $display("FAIL t4_nwrites got %0d want 1", n_wr - bw); else pass_cnt++;
    chk_cnt++; if (last_waddr !== 32'h2000) $display("FAIL t4_waddr got %h want 2000", last_waddr); else pass_cnt++;
    imem_ready = 1;
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    chk_cnt++; if ((n_wr - bw) !== 1) $display("FAIL t4_nwrites_after got %0d want 1", n_wr - bw); else pass_cnt++;
    base = n_rd;
    drive(0, 1, 32'h2000, 0);
    chk_cnt++; if (mem_ready !== 1'b0) $display("FAIL t4_ld_miss got %b want 0", mem_ready); else pass_cnt++;
    wait_ready(80, ok);
    chk_cnt++; if (!ok) $display("FAIL t4_ld_timeout got 0 want 1"); else pass_cnt++;
    chk_cnt++; if ((n_rd - base) !== 4) $display("FAIL t4_nreads got %0d want 4", n_rd - base); else pass_cnt++;
    chk_cnt++; if (mmo !== 32'hC0DE_2000) $display("FAIL t4_mmo got %h want C0DE2000", mmo); else pass_cnt++;
    drive(0, 0, 0, 0);
  endtask

  task automatic test_reset_mid_refill;
    int base; bit ok;
    reset = 1;
    @(negedge clock);
    reset = 0;
    base = n_rd;
    drive(0, 1, 32'h100, 0);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock); #1;
      if ((n_rd - base) >= 2) begin
        ok = 1'b1;
        break;
      end
    end
    chk_cnt++; if (!ok) $display("FAIL t5_second_ack_timeout got 0 want 1"); else pass_cnt++;
    reset = 1;
    #1;
    chk_cnt++; if (bus.req !== 1'b0) $display("FAIL t5_req_drop got %b want 0", bus.req); else pass_cnt++;
    @(negedge clock);
    reset = 0;
    base = n_rd;
    wait_ready(80, ok);
    chk_cnt++; if (!ok) $display("FAIL t5_timeout got 0 want 1"); else pass_cnt++;
    chk_cnt++; if ((n_rd - base) !== 4) $display("FAIL t5_nreads got %0d want 4", n_rd - base); else pass_cnt++;
    chk_cnt++; if (rd_log[base] !== 32'h100) $display("FAIL t5_first_addr got %h want 100", rd_log[base]); else pass_cnt++;
    chk_cnt++; if (rd_log[base+3] !== 32'h10C) $display("FAIL t5_last_addr got %h want 10C", rd_log[base+3]); else pass_cnt++;
    chk_cnt++; if (mmo !== 32'hC0DE_0100) $display("FAIL t5_mmo got %h want C0DE0100", mmo); else pass_cnt++;
    chk_cnt++; if (miss_cnt !== (STATS ? 32'd1 : 32'd0)) $display("FAIL t5_miss_cnt got %0d want %0d", miss_cnt, STATS ? 1 : 0); else pass_cnt++;
  endtask

  task automatic test_evict;
    bit ok;
    drive(0, 1, 32'h100, 0);
    chk_cnt++; if (mem_ready !== 1'b1) $display("FAIL t6_hit100 got %b want 1", mem_ready); else pass_cnt++;
    drive(0, 1, 32'h500, 0);
    chk_cnt++; if (mem_ready !== 1'b0) $display("FAIL t6_miss500 got %b want 0", mem_ready); else pass_cnt++;
    wait_ready(80, ok);
    chk_cnt++; if (mmo !== 32'hC0DE_0500 || !ok) $display("FAIL t6_mmo500 got %h want C0DE0500", mmo); else pass_cnt++;
    drive(0, 1, 32'h100, 0);
    chk_cnt++; if (mem_ready !== 1'b0) $display("FAIL t6_remiss100 got %b want 0", mem_ready); else pass_cnt++;
    wait_ready(80, ok);
    chk_cnt++; if (mmo !== 32'hC0DE_0100 || !ok) $display("FAIL t6_mmo100 got %h want C0DE0100", mmo); else pass_cnt++;
    drive(0, 0, 0, 0);
    chk_cnt++; if (miss_cnt !== (STATS ? 32'd3 : 32'd0)) $display("FAIL t6_miss_cnt got %0d want %0d", miss_cnt, STATS ? 3 : 0); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_refill();
    test_hit();
    test_store_hit();
    test_store_miss_stall();
    test_reset_mid_refill();
    test_evict();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
